// File: rtl/multi_adder_with_flow_control.sv
// N-operand adder with valid/ready flow control.
// Each operand channel feeds its own FIFO; the k-th beat of every channel is
// summed into the k-th result, which leaves through a 2-entry output buffer.
module multi_adder_with_flow_control #(
    parameter int unsigned Width     = 8,
    parameter int unsigned NInputs   = 3,
    parameter int unsigned FifoDepth = 4,
    localparam int unsigned SumW     = Width + $clog2(NInputs)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NInputs-1:0]         in_vld_i,
    output logic [NInputs-1:0]         in_rdy_o,
    input  logic [NInputs*Width-1:0]   in_data_i,
    output logic                       sum_vld_o,
    input  logic                       sum_rdy_i,
    output logic [SumW-1:0]            sum_data_o
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned CW = AW + 1;

    logic [Width-1:0]   mem_q    [NInputs][FifoDepth];
    logic [AW-1:0]      wr_ptr_q [NInputs];
    logic [AW-1:0]      rd_ptr_q [NInputs];
    logic [CW-1:0]      cnt_q    [NInputs];
    logic [CW-1:0]      cnt_d    [NInputs];
    logic [NInputs-1:0] rdy_q;
    logic [NInputs-1:0] push;
    logic [NInputs-1:0] not_empty;
    logic               out_can_accept;
    logic               fire;
    logic [SumW-1:0]    head_sum;

    logic [SumW-1:0]    main_q, main_d;
    logic               main_vld_q, main_vld_d;
    logic [SumW-1:0]    skid_q, skid_d;
    logic               skid_vld_q, skid_vld_d;
    logic               pop_out;

    // Ready is a registered !full flag, masked while reset is asserted.
    assign in_rdy_o       = rst_i ? '0 : rdy_q;
    assign out_can_accept = !skid_vld_q;
    assign fire           = (&not_empty) & out_can_accept;
    assign pop_out        = main_vld_q & sum_rdy_i;
    assign sum_vld_o      = main_vld_q;
    assign sum_data_o     = main_q;

    // Per-channel push/occupancy bookkeeping and the sum of all FIFO heads.
    always_comb begin
        push     = in_vld_i & in_rdy_o;
        head_sum = '0;
        for (int i = 0; i < NInputs; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
            cnt_d[i]     = cnt_q[i] + CW'(push[i]) - CW'(fire);
            head_sum     = head_sum + SumW'(mem_q[i][rd_ptr_q[i]]);
        end
    end

    // Input FIFOs: pointers, counts and the registered ready flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NInputs; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rdy_q <= '1;
        end else begin
            for (int i = 0; i < NInputs; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= in_data_i[i*Width +: Width];
                    wr_ptr_q[i]           <= wr_ptr_q[i] + AW'(1);
                end
                if (fire) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                cnt_q[i] <= cnt_d[i];
                rdy_q[i] <= (cnt_d[i] != CW'(FifoDepth));
            end
        end
    end

    // Output buffer next state: main holds the oldest result, skid the younger.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (pop_out) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                // Keep the last value on the bus rather than clearing it.
                main_vld_d = 1'b0;
            end
        end
        if (fire) begin
            if (!main_vld_d) begin
                main_d     = head_sum;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = head_sum;
                skid_vld_d = 1'b1;
            end
        end
    end

    // Output buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

endmodule
